rv32_fetch_unit: RTL and testbench

RV32_FETCH_UNIT -- requirements
Module: rv32_fetch_unit

---
 rtl/rv32_fetch_unit_pkg.sv | 27 ++
 rtl/rv32_fetch_unit_if.sv | 22 ++
 rtl/rv32_fetch_unit_skid_buf.sv | 64 ++++++
 rtl/rv32_fetch_unit.sv | 98 +++++++++
 tb/tb_rv32_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_fetch_unit_pkg.sv
// Shared rv32 fetch types: address/instruction words, fetch FSM states,
// the (instruction, pc) pair carried through the output stage, and a
// small alignment helper.
package rv32_fetch_unit_pkg;

   typedef logic [31:0] rv32_pc_cnt_t;
   typedef logic [31:0] rv32_instr_t;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } rv32_fetch_state_t;

   typedef struct packed {
      rv32_instr_t  instr;
      rv32_pc_cnt_t pc;
   } rv32_fetch_entry_t;

   localparam rv32_pc_cnt_t PC_STEP = 32'd4;

   // True when a byte address is on a 32-bit instruction boundary.
   function automatic logic pc_aligned(input rv32_pc_cnt_t pc);
      return (pc & rv32_pc_cnt_t'(3)) == '0;
   endfunction

endpackage

// File: rtl/rv32_fetch_unit_if.sv
// Instruction-memory read port: strobe and byte address out, read data
// back one cycle after the strobe.
interface rv32_fetch_unit_if;
   import rv32_fetch_unit_pkg::*;

   logic         imem_req;
   rv32_pc_cnt_t imem_addr;
   rv32_instr_t  imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata
   );

endinterface

// File: rtl/rv32_fetch_unit_skid_buf.sv
// Registered instruction output plus a one-entry skid buffer. A response
// that lands while the output is held by a stall parks in the skid entry
// and moves to the output on the next transfer, so nothing is dropped or
// repeated. A flush empties both stages.
module rv32_fetch_skid_buf
   import rv32_fetch_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   input  rv32_fetch_entry_t in_entry,
   output logic              out_valid,
   output rv32_fetch_entry_t out_entry,
   output logic              skid_full,
   output logic              xfer
);

   logic              out_valid_q;
   logic              skid_valid_q;
   rv32_fetch_entry_t out_q;
   rv32_fetch_entry_t skid_q;
   logic              load;

   // Stall only matters while something is being presented.
   assign xfer = out_valid_q && !stall;
   assign load = xfer || !out_valid_q;

   // Output stage refills from the skid entry first, else from the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_q        <= '0;
         skid_q       <= '0;
      end else if (flush) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (load) begin
         if (skid_valid_q) begin
            out_valid_q  <= 1'b1;
            out_q        <= skid_q;
            skid_valid_q <= in_valid;
            if (in_valid) begin
               skid_q <= in_entry;
            end
         end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
               out_q <= in_entry;
            end
         end
      end else if (in_valid) begin
         skid_valid_q <= 1'b1;
         skid_q       <= in_entry;
      end
   end

   assign out_valid = out_valid_q;
   assign out_entry = out_q;
   assign skid_full = skid_valid_q;

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32 instruction fetch: sequential PC generation, redirect handling with
// misalignment fault, and a registered/skid-buffered instruction output.
module rv32_fetch_unit
   import rv32_fetch_unit_pkg::*;
#(
   parameter rv32_pc_cnt_t RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rv32_has_new_pc,
   input  rv32_pc_cnt_t           rv32_next_pc_val,
   input  logic                   rv32_stall,
   rv32_fetch_unit_if.master      imem,
   output rv32_instr_t            rv32_instr,
   output rv32_pc_cnt_t           rv32_instr_pc,
   output logic                   rv32_instr_valid,
   output logic                   rv32_fetch_misalign,
   output logic [31:0]            rv32_fetch_cnt
);

   rv32_fetch_state_t state_q;
   rv32_pc_cnt_t      pc_q;
   rv32_pc_cnt_t      inflight_pc_q;
   logic              inflight_q;
   logic              misalign_q;
   logic [31:0]       cnt_q;

   logic              issue;
   logic              redirect_ok;
   logic              skid_full;
   logic              xfer;
   rv32_fetch_entry_t resp_entry;
   rv32_fetch_entry_t out_entry;

   assign redirect_ok = rv32_has_new_pc && pc_aligned(rv32_next_pc_val);

   // A request goes out only when its response is guaranteed a slot.
   assign issue = (state_q == ST_RUN) && !skid_full
                  && !(rv32_instr_valid && rv32_stall) && !rv32_has_new_pc;

   assign imem.imem_req  = issue;
   assign imem.imem_addr = pc_q;

   assign resp_entry = '{instr: imem.imem_rdata, pc: inflight_pc_q};

   // Fetch FSM, PC, in-flight tracking, fault flag and delivery counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         misalign_q    <= 1'b0;
         cnt_q         <= '0;
      end else begin
         if (xfer) begin
            cnt_q <= cnt_q + 32'd1;
         end
         inflight_q <= issue;
         if (issue) begin
            inflight_pc_q <= pc_q;
            pc_q          <= pc_q + PC_STEP;
         end
         if (rv32_has_new_pc) begin
            if (redirect_ok) begin
               state_q    <= ST_RUN;
               pc_q       <= rv32_next_pc_val;
               misalign_q <= 1'b0;
            end else begin
               state_q    <= ST_FAULT;
               misalign_q <= 1'b1;
            end
         end else if (state_q == ST_BOOT) begin
            state_q <= ST_RUN;
         end
      end
   end

   // Redirect flushes the output stage and the response landing this cycle.
   rv32_fetch_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (rv32_has_new_pc),
      .stall     (rv32_stall),
      .in_valid  (inflight_q),
      .in_entry  (resp_entry),
      .out_valid (rv32_instr_valid),
      .out_entry (out_entry),
      .skid_full (skid_full),
      .xfer      (xfer)
   );

   assign rv32_instr          = out_entry.instr;
   assign rv32_instr_pc       = out_entry.pc;
   assign rv32_fetch_misalign = misalign_q;
   assign rv32_fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Bench for rv32_fetch_unit: directed cycle table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_rv32_fetch_unit;
   import rv32_fetch_unit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, stall, has_new_pc;
   rv32_pc_cnt_t next_pc;
   rv32_instr_t  instr;
   rv32_pc_cnt_t instr_pc;
   logic         instr_valid, misalign;
   logic [31:0]  fcnt;

   logic         rst2, stall2, has_new_pc2;
   rv32_pc_cnt_t next_pc2;
   rv32_instr_t  instr2;
   rv32_pc_cnt_t instr_pc2;
   logic         instr_valid2, misalign2;
   logic [31:0]  fcnt2;

   rv32_fetch_unit_if bus ();
   rv32_fetch_unit_if bus2 ();

   rv32_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .rv32_has_new_pc(has_new_pc), .rv32_next_pc_val(next_pc),
      .rv32_stall(stall), .imem(bus), .rv32_instr(instr), .rv32_instr_pc(instr_pc),
      .rv32_instr_valid(instr_valid), .rv32_fetch_misalign(misalign), .rv32_fetch_cnt(fcnt)
   );

   rv32_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .rst(rst2), .rv32_has_new_pc(has_new_pc2), .rv32_next_pc_val(next_pc2),
      .rv32_stall(stall2), .imem(bus2), .rv32_instr(instr2), .rv32_instr_pc(instr_pc2),
      .rv32_instr_valid(instr_valid2), .rv32_fetch_misalign(misalign2), .rv32_fetch_cnt(fcnt2)
   );

   // Memory contents: a bijective scramble of the address.
   function automatic rv32_instr_t mem_word(input rv32_pc_cnt_t a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   // Synchronous memories; data without a request is deliberately wrong.
   always @(posedge clk) begin
      bus.imem_rdata  <= bus.imem_req  ? mem_word(bus.imem_addr)  : ~mem_word(bus.imem_addr);
      bus2.imem_rdata <= bus2.imem_req ? mem_word(bus2.imem_addr) : ~mem_word(bus2.imem_addr);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: pending deliveries as a queue (head = shown word).
   bit           m_boot, m_fault, m_inf;
   rv32_pc_cnt_t m_pc, m_inf_pc;
   rv32_pc_cnt_t m_q[$];
   logic [31:0]  m_cnt;

   task automatic model_reset();
      m_boot = 1; m_fault = 0; m_inf = 0; m_pc = 32'h0; m_inf_pc = 32'h0;
      m_q.delete(); m_cnt = 32'h0;
   endtask

   function automatic bit m_req();
      return !m_boot && !m_fault && !has_new_pc &&
             (m_q.size() == 0 || (m_q.size() == 1 && !stall));
   endfunction

   task automatic model_step();
      bit req, xfer;
      if (rst) begin
         model_reset();
         return;
      end
      req  = m_req();
      xfer = (m_q.size() > 0) && !stall;
      if (xfer) m_cnt = m_cnt + 32'd1;
      if (has_new_pc) begin
         m_q.delete();
         m_inf  = 0;
         m_boot = 0;
         if (next_pc[1:0] == 2'b00) begin
            m_pc    = next_pc;
            m_fault = 0;
         end else begin
            m_fault = 1;
         end
      end else begin
         if (xfer) void'(m_q.pop_front());
         if (m_inf) m_q.push_back(m_inf_pc);
         m_inf = req;
         if (req) begin
            m_inf_pc = m_pc;
            m_pc     = m_pc + 32'd4;
         end
         m_boot = 0;
      end
   endtask

   task automatic check_model();
      check("req", bus.imem_req, m_req());
      if (m_req()) check("addr", bus.imem_addr, m_pc);
      check("valid", instr_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
         check("instr_pc", instr_pc, m_q[0]);
         check("instr", instr, mem_word(m_q[0]));
      end
      check("misalign", misalign, m_fault);
      check("fetch_cnt", fcnt, m_cnt);
   endtask

   // One cycle: inputs already driven at the falling edge.
   task automatic cyc();
      #1;
      check_model();
      model_step();
      @(negedge clk);
   endtask

   typedef struct {
      bit           rst, stall, newpc;
      rv32_pc_cnt_t target;
      bit           e_req;
      rv32_pc_cnt_t e_addr;
      bit           e_valid;
      rv32_pc_cnt_t e_pc;
      bit           e_mis;
      logic [31:0]  e_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input bit s, input bit n, input rv32_pc_cnt_t t,
                      input bit er, input rv32_pc_cnt_t ea, input bit ev,
                      input rv32_pc_cnt_t ep, input bit em, input logic [31:0] ec);
      vec_t v;
      v = '{rst: r, stall: s, newpc: n, target: t, e_req: er, e_addr: ea,
            e_valid: ev, e_pc: ep, e_mis: em, e_cnt: ec};
      tbl.push_back(v);
   endtask

   rv32_pc_cnt_t got2[$];
   rv32_instr_t  got2_i[$];
   int           first_k;

   initial begin
      //    rst s n target      req addr     v pc       mis cnt
      add(1, 0, 0, 32'h0,      0, 32'h0,   0, 32'h0,   0, 0);  // reset state
      add(0, 0, 0, 32'h0,      0, 32'h0,   0, 32'h0,   0, 0);  // BOOT, no request
      add(0, 0, 0, 32'h0,      1, 32'h0,   0, 32'h0,   0, 0);
      add(0, 0, 0, 32'h0,      1, 32'h4,   0, 32'h0,   0, 0);
      add(0, 0, 0, 32'h0,      1, 32'h8,   1, 32'h0,   0, 0);
      add(0, 0, 0, 32'h0,      1, 32'hC,   1, 32'h4,   0, 1);
      add(0, 1, 0, 32'h0,      0, 32'h0,   1, 32'h8,   0, 2);  // stall x3 at pc 8
      add(0, 1, 0, 32'h0,      0, 32'h0,   1, 32'h8,   0, 2);
      add(0, 1, 0, 32'h0,      0, 32'h0,   1, 32'h8,   0, 2);
      add(0, 0, 0, 32'h0,      0, 32'h0,   1, 32'h8,   0, 2);  // skid still full
      add(0, 0, 0, 32'h0,      1, 32'h10,  1, 32'hC,   0, 3);
      add(0, 0, 0, 32'h0,      1, 32'h14,  0, 32'h0,   0, 4);
      add(0, 0, 1, 32'h102,    0, 32'h0,   1, 32'h10,  0, 4);  // misaligned redirect
      add(0, 0, 0, 32'h0,      0, 32'h0,   0, 32'h0,   1, 5);
      add(0, 1, 0, 32'h0,      0, 32'h0,   0, 32'h0,   1, 5);
      add(0, 0, 1, 32'h200,    0, 32'h0,   0, 32'h0,   1, 5);  // recover
      add(0, 0, 0, 32'h0,      1, 32'h200, 0, 32'h0,   0, 5);
      add(0, 0, 0, 32'h0,      1, 32'h204, 0, 32'h0,   0, 5);
      add(0, 0, 0, 32'h0,      1, 32'h208, 1, 32'h200, 0, 5);
      add(0, 0, 1, 32'h100,    0, 32'h0,   1, 32'h204, 0, 6);  // redirect, 0x208 in flight
      add(0, 0, 0, 32'h0,      1, 32'h100, 0, 32'h0,   0, 7);
      add(0, 0, 0, 32'h0,      1, 32'h104, 0, 32'h0,   0, 7);
      add(0, 0, 0, 32'h0,      1, 32'h108, 1, 32'h100, 0, 7);

      rst = 1; stall = 0; has_new_pc = 0; next_pc = '0;
      rst2 = 1; stall2 = 0; has_new_pc2 = 0; next_pc2 = '0;
      model_reset();
      repeat (2) @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; stall = tbl[i].stall;
         has_new_pc = tbl[i].newpc; next_pc = tbl[i].target;
         #1;
         check($sformatf("t%0d_req", i), bus.imem_req, tbl[i].e_req);
         if (tbl[i].e_req) check($sformatf("t%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
         check($sformatf("t%0d_valid", i), instr_valid, tbl[i].e_valid);
         if (tbl[i].e_valid) begin
            check($sformatf("t%0d_pc", i), instr_pc, tbl[i].e_pc);
            check($sformatf("t%0d_instr", i), instr, mem_word(tbl[i].e_pc));
         end
         check($sformatf("t%0d_mis", i), misalign, tbl[i].e_mis);
         check($sformatf("t%0d_cnt", i), fcnt, tbl[i].e_cnt);
         if (i == 0) begin
            check("t0_instr_rst", instr, 32'h0);
            check("t0_pc_rst", instr_pc, 32'h0);
         end
         model_step();
         @(negedge clk);
      end

      // Redirect while stalled with the skid full: redirect wins, no transfer.
      has_new_pc = 0; stall = 0;
      repeat (3) cyc();
      stall = 1;
      repeat (2) cyc();
      has_new_pc = 1; next_pc = 32'h300;
      cyc();
      has_new_pc = 0; stall = 0;
      repeat (5) cyc();

      // Reset asserted mid-stall with the skid full.
      stall = 1;
      repeat (3) cyc();
      rst = 1;
      cyc();
      rst = 0; stall = 0;
      #1;
      check("rst_valid", instr_valid, 1'b0);
      check("rst_req", bus.imem_req, 1'b0);
      check("rst_mis", misalign, 1'b0);
      check("rst_cnt", fcnt, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc", instr_pc, 32'h0);
      for (int k = 0; k < 10 && !instr_valid; k++) cyc();
      check("restart_valid", instr_valid, 1'b1);
      check("restart_pc", instr_pc, 32'h0);

      // Reset while a request is in flight: its response must not surface.
      repeat (4) cyc();
      rst = 1;
      cyc();
      rst = 0;
      repeat (4) cyc();

      // Randomized traffic.
      for (int k = 0; k < 600; k++) begin
         rst   = ($urandom_range(0, 199) == 0);
         stall = ($urandom_range(0, 9) < 3);
         has_new_pc = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       next_pc = 32'hFFFF_FFF0;
            1:       next_pc = $urandom() | 32'h1;
            default: next_pc = $urandom() & ~32'h3;
         endcase
         cyc();
      end
      rst = 0; stall = 0; has_new_pc = 0;
      repeat (3) cyc();

      // Second instance: PC wrap from RESET_PC = FFFF_FFF8.
      rst2 = 0;
      first_k = -1;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (instr_valid2) begin
            if (first_k < 0) first_k = k;
            got2.push_back(instr_pc2);
            got2_i.push_back(instr2);
         end
         @(negedge clk);
      end
      #1;
      check("wrap_first_cycle", first_k, 3);
      check("wrap_count", got2.size(), 9);
      check("wrap_cnt", fcnt2, got2.size());
      check("wrap_mis", misalign2, 1'b0);
      if (got2.size() >= 3) begin
         check("wrap_pc0", got2[0], 32'hFFFF_FFF8);
         check("wrap_pc1", got2[1], 32'hFFFF_FFFC);
         check("wrap_pc2", got2[2], 32'h0000_0000);
         check("wrap_i0", got2_i[0], mem_word(32'hFFFF_FFF8));
         check("wrap_i2", got2_i[2], mem_word(32'h0000_0000));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
